// File: rtl/blake2_digest_streamer.sv
// blake2_digest_streamer
//
// Output stage behind blake2_core. On a rising edge of digest_valid it captures
// the 512-bit digest, keeps only the top DIGEST_BYTES bytes, and streams them
// most-significant word first over a BUS_WIDTH-wide valid/ready bus.
//
// Ports:
//   clk, reset_n      rising-edge clock, synchronous active-low reset
//   digest_valid      level from the core; only its rising edge starts a send
//   digest[511:0]     digest, meaningful bytes in the top bits
//   dout              current output word
//   dout_valid        dout / dout_keep / dout_last are valid
//   dout_ready        sink accepts the word
//   dout_keep         byte mask, bit i qualifies dout[8i+7:8i]
//   dout_last         final word of the digest
//   busy              a digest is held and not yet fully accepted
//   overrun           sticky: a digest arrived while busy and was dropped
//
// Handshake: a word transfers on a rising edge where dout_valid & dout_ready are
// both high. Once dout_valid is high it stays high, with dout/dout_keep/dout_last
// unchanged, until that transfer happens; only reset can withdraw it.
// All outputs are decoded from registers only, so dout_ready never reaches an
// output combinationally.

module blake2_digest_streamer #(
    parameter int BUS_WIDTH    = 64,
    parameter int DIGEST_BYTES = 11
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   digest_valid,
    input  logic [511:0]           digest,
    output logic [BUS_WIDTH-1:0]   dout,
    output logic                   dout_valid,
    input  logic                   dout_ready,
    output logic [BUS_WIDTH/8-1:0] dout_keep,
    output logic                   dout_last,
    output logic                   busy,
    output logic                   overrun
);

    localparam int BPW        = BUS_WIDTH / 8;
    localparam int NUM_WORDS  = (DIGEST_BYTES * 8 + BUS_WIDTH - 1) / BUS_WIDTH;
    localparam int LAST_BYTES = DIGEST_BYTES - (NUM_WORDS - 1) * BPW;
    localparam int WCNT_W     = $clog2(NUM_WORDS + 1);

    // Keeps only the meaningful digest bytes. Masking at capture means the
    // shift register is all zero once the last word has shifted out, so the
    // idle dout is 0 with no extra gating.
    localparam logic [511:0]   CAP_MASK  = ~({512{1'b1}} >> (8 * DIGEST_BYTES));
    localparam logic [BPW-1:0] LAST_KEEP = ~({BPW{1'b1}} >> LAST_BYTES);
    localparam logic [WCNT_W-1:0] LAST_IDX = WCNT_W'(NUM_WORDS - 1);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [511:0]      sreg_q, sreg_d;
    logic [WCNT_W-1:0] wcnt_q, wcnt_d;
    logic              dv_q, dv_d;
    logic              overrun_q, overrun_d;

    logic cap;
    logic xfer;
    logic final_xfer;
    logic on_last;

    assign cap        = digest_valid & ~dv_q;
    assign on_last    = (wcnt_q == LAST_IDX);
    assign xfer       = (state_q == SEND) & dout_ready;
    assign final_xfer = xfer & on_last;

    always_comb begin
        state_d   = state_q;
        sreg_d    = sreg_q;
        wcnt_d    = wcnt_q;
        overrun_d = overrun_q;
        dv_d      = digest_valid;

        case (state_q)
            IDLE: begin
                if (cap) begin
                    sreg_d  = digest & CAP_MASK;
                    wcnt_d  = '0;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (xfer) begin
                    sreg_d = sreg_q << BUS_WIDTH;
                    wcnt_d = wcnt_q + 1'b1;
                end
                if (final_xfer) begin
                    if (cap) begin
                        // Back-to-back: the new digest follows with no bubble.
                        sreg_d = digest & CAP_MASK;
                        wcnt_d = '0;
                    end else begin
                        wcnt_d  = '0;
                        state_d = IDLE;
                    end
                end else if (cap) begin
                    // Held data wins; the newcomer is dropped and flagged.
                    overrun_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            sreg_q    <= '0;
            wcnt_q    <= '0;
            // Starts high so a level already present at reset is not a rise.
            dv_q      <= 1'b1;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sreg_q    <= sreg_d;
            wcnt_q    <= wcnt_d;
            dv_q      <= dv_d;
            overrun_q <= overrun_d;
        end
    end

    assign dout       = sreg_q[511 -: BUS_WIDTH];
    assign dout_valid = (state_q == SEND);
    assign busy       = (state_q == SEND);
    assign dout_last  = (state_q == SEND) & on_last;
    assign dout_keep  = (state_q != SEND) ? '0 :
                        (on_last ? LAST_KEEP : {BPW{1'b1}});
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_blake2_digest_streamer.sv
// Directed bench for blake2_digest_streamer: default 11-byte/64-bit instance
// plus a 64-byte instance for the full-length case.

module tb_blake2_digest_streamer;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset_n;
    logic         dv, dv64;
    logic [511:0] digest;
    logic         ready, ready64;

    logic [63:0]  dout, dout64;
    logic         dout_valid, dout_valid64;
    logic [7:0]   dout_keep, dout_keep64;
    logic         dout_last, dout_last64;
    logic         busy, busy64;
    logic         overrun, overrun64;

    blake2_digest_streamer #(.BUS_WIDTH(64), .DIGEST_BYTES(11)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .digest_valid (dv),
        .digest       (digest),
        .dout         (dout),
        .dout_valid   (dout_valid),
        .dout_ready   (ready),
        .dout_keep    (dout_keep),
        .dout_last    (dout_last),
        .busy         (busy),
        .overrun      (overrun)
    );

    blake2_digest_streamer #(.BUS_WIDTH(64), .DIGEST_BYTES(64)) dut64 (
        .clk          (clk),
        .reset_n      (reset_n),
        .digest_valid (dv64),
        .digest       (digest),
        .dout         (dout64),
        .dout_valid   (dout_valid64),
        .dout_ready   (ready64),
        .dout_keep    (dout_keep64),
        .dout_last    (dout_last64),
        .busy         (busy64),
        .overrun      (overrun64)
    );

    // ---------------- scoreboard ----------------
    int          errors = 0;
    int          checks = 0;
    logic [63:0] exp_q[$];

    // Digest D1: byte i = i+1. Digest D2: byte i = 0xA0+i.
    logic [511:0] d1, d2;

    localparam logic [63:0] D1_W0 = 64'h0102030405060708;
    localparam logic [63:0] D1_W1 = 64'h090A0B0000000000;
    localparam logic [63:0] D2_W0 = 64'hA0A1A2A3A4A5A6A7;
    localparam logic [63:0] D2_W1 = 64'hA8A9AA0000000000;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Inputs change 1ns after the rising edge; outputs are sampled at the same
    // point, i.e. they reflect the edge just taken.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_word(input string tag, input logic [63:0] w, input logic [7:0] k,
                            input logic l);
        chk({tag, ".valid"}, 64'(dout_valid), 64'd1);
        chk({tag, ".dout"},  dout, w);
        chk({tag, ".keep"},  64'(dout_keep), 64'(k));
        chk({tag, ".last"},  64'(dout_last), 64'(l));
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".valid"}, 64'(dout_valid), 64'd0);
        chk({tag, ".busy"},  64'(busy), 64'd0);
        chk({tag, ".dout"},  dout, 64'd0);
        chk({tag, ".keep"},  64'(dout_keep), 64'd0);
        chk({tag, ".last"},  64'(dout_last), 64'd0);
    endtask

    int n;

    initial begin
        for (int i = 0; i < 64; i++) begin
            d1[511-8*i -: 8] = 8'(i + 1);
            d2[511-8*i -: 8] = 8'(8'hA0 + i);
        end

        reset_n = 1'b0; dv = 1'b0; dv64 = 1'b0;
        digest = d1; ready = 1'b1; ready64 = 1'b1;
        step(); step();

        // Reset values
        chk_idle("reset");
        chk("reset.overrun", 64'(overrun), 64'd0);
        chk_idle("reset_after_rel_prep");
        reset_n = 1'b1;
        step();

        // 1: single digest, ready high
        digest = d1; dv = 1'b1;
        exp_q.push_back(D1_W0);
        exp_q.push_back(D1_W1);
        step();
        chk("t1.busy0", 64'(busy), 64'd1);
        chk_word("t1.w0", exp_q.pop_front(), 8'hFF, 1'b0);
        step();
        chk("t1.busy1", 64'(busy), 64'd1);
        chk_word("t1.w1", exp_q.pop_front(), 8'hE0, 1'b1);
        step();
        chk_idle("t1.end");
        chk("t1.overrun", 64'(overrun), 64'd0);
        dv = 1'b0;
        step();

        // 2: backpressure
        ready = 1'b0; digest = d2; dv = 1'b1;
        step();
        dv = 1'b0;
        chk_word("t2.w0", D2_W0, 8'hFF, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step();
            chk_word("t2.stall0", D2_W0, 8'hFF, 1'b0);
        end
        ready = 1'b1;
        step();
        chk_word("t2.w1", D2_W1, 8'hE0, 1'b1);
        ready = 1'b0;
        step();
        chk_word("t2.stall1", D2_W1, 8'hE0, 1'b1);
        ready = 1'b1;
        step();
        chk_idle("t2.end");
        step();
        chk_idle("t2.nodup");

        // 3: level held for 50 cycles -> one digest only
        digest = d1; dv = 1'b1; n = 0;
        for (int i = 0; i < 50; i++) begin
            step();
            if (dout_valid) n++;
        end
        chk("t3.words_held", 64'(n), 64'd2);
        dv = 1'b0;
        step();
        dv = 1'b1; n = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (dout_valid) n++;
        end
        chk("t3.words_rerise", 64'(n), 64'd2);
        chk("t3.overrun", 64'(overrun), 64'd0);
        dv = 1'b0;
        step();

        // 4: overrun while word 0 is stalled
        ready = 1'b0; digest = d1; dv = 1'b1;
        step();
        dv = 1'b0; digest = d2;
        step();
        dv = 1'b1;
        step();
        chk("t4.overrun", 64'(overrun), 64'd1);
        chk_word("t4.w0", D1_W0, 8'hFF, 1'b0);
        ready = 1'b1; dv = 1'b0;
        step();
        chk_word("t4.w1", D1_W1, 8'hE0, 1'b1);
        step();
        chk_idle("t4.end");
        chk("t4.overrun_sticky", 64'(overrun), 64'd1);
        reset_n = 1'b0;
        step();
        chk("t4.overrun_reset", 64'(overrun), 64'd0);
        reset_n = 1'b1;
        step();

        // 5: new rise coincident with the final transfer
        digest = d1; dv = 1'b1;
        step();
        chk_word("t5.a_w0", D1_W0, 8'hFF, 1'b0);
        dv = 1'b0;
        step();
        chk_word("t5.a_w1", D1_W1, 8'hE0, 1'b1);
        digest = d2; dv = 1'b1;
        step();
        chk("t5.busy", 64'(busy), 64'd1);
        chk_word("t5.b_w0", D2_W0, 8'hFF, 1'b0);
        chk("t5.overrun", 64'(overrun), 64'd0);
        step();
        chk_word("t5.b_w1", D2_W1, 8'hE0, 1'b1);
        step();
        chk_idle("t5.end");
        dv = 1'b0;
        step();

        // 6: reset after word 0 transfers
        digest = d1; dv = 1'b1;
        step();
        chk_word("t6.w0", D1_W0, 8'hFF, 1'b0);
        step();
        reset_n = 1'b0;
        step();
        chk_idle("t6.reset");
        chk("t6.overrun", 64'(overrun), 64'd0);
        reset_n = 1'b1;
        step();
        chk_idle("t6.noresume0");
        step();
        chk_idle("t6.noresume1");
        dv = 1'b0;
        step();

        // 7: 64-byte digest, 8 full words
        for (int k = 0; k < 8; k++) begin
            logic [63:0] e;
            for (int j = 0; j < 8; j++) e[63-8*j -: 8] = 8'(8 * k + j + 1);
            exp_q.push_back(e);
        end
        digest = d1; dv64 = 1'b1;
        step();
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("t7.w%0d.valid", k), 64'(dout_valid64), 64'd1);
            chk($sformatf("t7.w%0d.dout", k), dout64, exp_q.pop_front());
            chk($sformatf("t7.w%0d.keep", k), 64'(dout_keep64), 64'hFF);
            chk($sformatf("t7.w%0d.last", k), 64'(dout_last64), 64'(k == 7));
            step();
        end
        chk("t7.end.valid", 64'(dout_valid64), 64'd0);
        chk("t7.end.busy", 64'(busy64), 64'd0);
        chk("t7.overrun", 64'(overrun64), 64'd0);
        dv64 = 1'b0;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
